sdram_arbiter: RTL

//  Shares the single SDRAM port between two requesters: the HPS download path (ROM/background

---
 rtl/sdram_arbiter_pkg.sv | 10 +
 rtl/sdram_arbiter_if.sv | 27 ++
 rtl/sdram_req_slot.sv | 22 ++
 rtl/sdram_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared constants and FSM state encoding for the SDRAM arbiter
package sdram_arbiter_pkg;
   localparam int ADDR_W = 25;
   localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t IDLE     = 2'd0;
   localparam arb_state_t ISSUE_WR = 2'd1;
   localparam arb_state_t ISSUE_RD = 2'd2;
   localparam arb_state_t WAIT     = 2'd3;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: download, renderer and SDRAM controller signals around the arbiter
interface sdram_arbiter_if import sdram_arbiter_pkg::*; #(parameter int AW = ADDR_W) ();
   logic          dl_active;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          dl_wr;
   logic          dl_wait;
   logic [AW-1:0] vfd_addr;
   logic          vfd_rd;
   logic [7:0]    vfd_data;
   logic          vfd_valid;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_rd;
   logic          mem_we;
   logic [7:0]    mem_dout;
   logic          mem_ready;
   logic          err;
   modport slave (
      input  dl_active, dl_addr, dl_data, dl_wr, vfd_addr, vfd_rd, mem_dout, mem_ready,
      output dl_wait, vfd_data, vfd_valid, mem_addr, mem_din, mem_rd, mem_we, err
   );
   modport master (
      output dl_active, dl_addr, dl_data, dl_wr, vfd_addr, vfd_rd, mem_dout, mem_ready,
      input  dl_wait, vfd_data, vfd_valid, mem_addr, mem_din, mem_rd, mem_we, err
   );
endinterface

// File: rtl/sdram_req_slot.sv
// sdram_req_slot: one-deep request holding register with full flag
module sdram_req_slot #(parameter int W = 25) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] payload,
   output logic         full,
   output logic [W-1:0] q
);
   // A slot being freed this edge may be refilled on the same edge, keeping streams gapless
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         full <= 1'b0;
         q    <= '0;
      end else if (load && (!full || clear)) begin
         full <= 1'b1;
         q    <= payload;
      end else if (clear) begin
         full <= 1'b0;
      end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM port between HPS download writes and VFD pixel reads
module sdram_arbiter import sdram_arbiter_pkg::*; #(
   parameter int ADDR_W       = 25,
   parameter int MAX_WR_BURST = 4,
   parameter int TIMEOUT      = 255
) (
   input logic             clk,
   input logic             reset,
   sdram_arbiter_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(MAX_WR_BURST + 1);
   arb_state_t      state;
   logic [TW-1:0]   timer;
   logic [BW-1:0]   wr_burst;
   logic            rd_cmd;
   logic            wr_full, rd_full, rd_win, wr_win, timeout, done;
   logic [ADDR_W+7:0] wr_slot;
   logic [ADDR_W-1:0] rd_slot;
   sdram_req_slot #(.W(ADDR_W + 8)) u_wr_slot (
      .clk(clk), .reset(reset), .load(bus.dl_wr), .clear(done && !rd_cmd),
      .payload({bus.dl_data, bus.dl_addr}), .full(wr_full), .q(wr_slot)
   );
   sdram_req_slot #(.W(ADDR_W)) u_rd_slot (
      .clk(clk), .reset(reset), .load(bus.vfd_rd), .clear(done && rd_cmd),
      .payload(bus.vfd_addr), .full(rd_full), .q(rd_slot)
   );
   assign timeout     = timer == TW'(TIMEOUT);
   assign done        = state == WAIT && (bus.mem_ready || timeout);
   assign rd_win      = rd_full && (!bus.dl_active || !wr_full || wr_burst == BW'(MAX_WR_BURST));
   assign wr_win      = wr_full && !rd_win;
   assign bus.mem_rd  = state == ISSUE_RD;
   assign bus.mem_we  = state == ISSUE_WR;
   assign bus.dl_wait = wr_full;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         wr_burst      <= '0;
         rd_cmd        <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_din   <= '0;
         bus.vfd_data  <= '0;
         bus.vfd_valid <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.vfd_valid <= 1'b0;
         case (state)
            IDLE:
               if (rd_win) begin
                  state        <= ISSUE_RD;
                  rd_cmd       <= 1'b1;
                  bus.mem_addr <= rd_slot;
                  wr_burst     <= '0;
               end else if (wr_win) begin
                  state        <= ISSUE_WR;
                  rd_cmd       <= 1'b0;
                  bus.mem_addr <= wr_slot[ADDR_W-1:0];
                  bus.mem_din  <= wr_slot[ADDR_W +: 8];
                  // only writes that starve a waiting read count toward the burst limit
                  if (rd_full && wr_burst != BW'(MAX_WR_BURST)) wr_burst <= wr_burst + 1'b1;
               end
            ISSUE_WR, ISSUE_RD: begin
               state <= WAIT;
               timer <= '0;
            end
            default:
               if (done) begin
                  state <= IDLE;
                  if (rd_cmd) begin
                     bus.vfd_data  <= bus.mem_ready ? bus.mem_dout : RD_TIMEOUT_DATA;
                     bus.vfd_valid <= 1'b1;
                  end
                  if (!bus.mem_ready) bus.err <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
         endcase
      end
endmodule
